// File: rtl/gat_pkg.sv
// Shared types and default sizing for the GAT accelerator blocks.
package gat_pkg;

   localparam int NEW_FEATURE_WIDTH = 32;
   localparam int NUM_SUBGRAPHS     = 2708;
   localparam int NUM_FEATURE_OUT   = 16;
   localparam int NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } feat_rd_state_t;

endpackage

// File: rtl/gat_feat_rd_fifo.sv
// Small first-word-fall-through FIFO built as a shift chain so the head entry
// is always a flop; entry 0 drives the stream outputs directly.
module gat_feat_rd_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] data_reg [DEPTH];
   logic [DEPTH-1:0] vld_reg;
   logic [CNT_W-1:0] count_reg;

   // View of the entry above each slot; the top slot sees an empty entry.
   logic [WIDTH-1:0] up_data [DEPTH+1];
   logic [DEPTH:0]   up_vld;
   logic [CNT_W-1:0] wr_slot;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_up
         assign up_data[gi] = data_reg[gi];
         assign up_vld[gi]  = vld_reg[gi];
      end
   endgenerate
   assign up_data[DEPTH] = '0;
   assign up_vld[DEPTH]  = 1'b0;

   // A simultaneous pop shifts everything down, so the write lands one lower.
   assign wr_slot = pop ? (count_reg - 1'b1) : count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_reg[i] <= '0;
         end
         vld_reg   <= '0;
         count_reg <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_slot == CNT_W'(i))) begin
               data_reg[i] <= push_data;
               vld_reg[i]  <= 1'b1;
            end else if (pop) begin
               data_reg[i] <= up_data[i+1];
               vld_reg[i]  <= up_vld[i+1];
            end
         end
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head_data  = data_reg[0];
   assign head_valid = vld_reg[0];
   assign count      = count_reg;

endmodule

// File: rtl/gat_feat_bram_reader.sv
// Walks the GAT output feature BRAM and streams every word out over AXI4-Stream,
// issuing reads only when the output buffer is guaranteed room for the result.
module gat_feat_bram_reader #(
   parameter int NEW_FEATURE_WIDTH  = gat_pkg::NEW_FEATURE_WIDTH,
   parameter int NUM_SUBGRAPHS      = gat_pkg::NUM_SUBGRAPHS,
   parameter int NUM_FEATURE_OUT    = gat_pkg::NUM_FEATURE_OUT,
   parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
   parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
   parameter int BRAM_RD_LATENCY    = 2,
   parameter int FIFO_DEPTH         = BRAM_RD_LATENCY + 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
   output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser
);
   import gat_pkg::*;

   localparam int L      = BRAM_RD_LATENCY;
   localparam int AW     = NEW_FEATURE_ADDR_W;
   localparam int FW     = NEW_FEATURE_WIDTH + 2;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int NODE_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;

   feat_rd_state_t    state_reg;
   logic              busy_reg, done_reg;
   logic [AW-1:0]     rd_idx_reg, issue_idx;
   logic [NODE_W-1:0] node_pos_reg, issue_pos;
   logic [AW+1:0]     addr_reg;
   logic              addr_vld_reg, addr_last_reg, addr_user_reg;
   logic [L-1:0]      vld_pipe_reg, last_pipe_reg, user_pipe_reg;
   logic [L-1:0]      vld_pipe_next, last_pipe_next, user_pipe_next;

   logic              issue, issue_last, issue_user, credit_ok;
   int                inflight;
   logic              fifo_push, fifo_pop, fifo_head_vld;
   logic [FW-1:0]     fifo_head, fifo_push_data;
   logic [CNT_W-1:0]  fifo_count;

   // Word counter restarts from zero on the accepting start cycle itself.
   always_comb begin
      issue_idx  = (state_reg == ST_IDLE) ? '0 : rd_idx_reg;
      issue_pos  = (state_reg == ST_IDLE) ? '0 : node_pos_reg;
      issue_last = (issue_idx == AW'(NEW_FEATURE_DEPTH - 1));
      issue_user = (issue_pos == '0);
      inflight   = int'(addr_vld_reg);
      for (int i = 0; i < L; i++) begin
         inflight = inflight + int'(vld_pipe_reg[i]);
      end
      credit_ok = (inflight + int'(fifo_count) + 1 - int'(fifo_pop)) <= FIFO_DEPTH;
      issue     = credit_ok && (((state_reg == ST_IDLE) && start) || (state_reg == ST_READ));
   end

   // The address stage is the first slot; the latency chain follows it.
   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_lat
         if (gi == 0) begin : g_head
            assign vld_pipe_next[gi]  = addr_vld_reg;
            assign last_pipe_next[gi] = addr_last_reg;
            assign user_pipe_next[gi] = addr_user_reg;
         end else begin : g_tail
            assign vld_pipe_next[gi]  = vld_pipe_reg[gi-1];
            assign last_pipe_next[gi] = last_pipe_reg[gi-1];
            assign user_pipe_next[gi] = user_pipe_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         rd_idx_reg    <= '0;
         node_pos_reg  <= '0;
         addr_reg      <= '0;
         addr_vld_reg  <= 1'b0;
         addr_last_reg <= 1'b0;
         addr_user_reg <= 1'b0;
         vld_pipe_reg  <= '0;
         last_pipe_reg <= '0;
         user_pipe_reg <= '0;
      end else begin
         done_reg      <= 1'b0;
         addr_vld_reg  <= issue;
         vld_pipe_reg  <= vld_pipe_next;
         last_pipe_reg <= last_pipe_next;
         user_pipe_reg <= user_pipe_next;
         if (issue) begin
            addr_reg      <= {issue_idx, 2'b00};
            addr_last_reg <= issue_last;
            addr_user_reg <= issue_user;
            rd_idx_reg    <= issue_idx + 1'b1;
            node_pos_reg  <= (issue_pos == NODE_W'(NUM_FEATURE_OUT - 1)) ? '0 : issue_pos + 1'b1;
         end
         case (state_reg)
            ST_IDLE: begin
               if (issue) begin
                  busy_reg  <= 1'b1;
                  state_reg <= issue_last ? ST_DRAIN : ST_READ;
               end
            end
            ST_READ: begin
               if (issue && issue_last) begin
                  state_reg <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (fifo_pop && fifo_head[FW-1]) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign fifo_push      = vld_pipe_reg[L-1];
   assign fifo_push_data = {last_pipe_reg[L-1], user_pipe_reg[L-1], feat_bram_dout};
   assign fifo_pop       = fifo_head_vld & m_axis_tready;

   gat_feat_rd_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push),
      .push_data  (fifo_push_data),
      .pop        (fifo_pop),
      .head_data  (fifo_head),
      .head_valid (fifo_head_vld),
      .count      (fifo_count)
   );

   assign feat_bram_addrb = addr_reg;
   assign m_axis_tdata    = fifo_head[NEW_FEATURE_WIDTH-1:0];
   assign m_axis_tuser    = fifo_head[NEW_FEATURE_WIDTH];
   assign m_axis_tlast    = fifo_head[NEW_FEATURE_WIDTH+1];
   assign m_axis_tvalid   = fifo_head_vld;
   assign busy            = busy_reg;
   assign done            = done_reg;

endmodule
